shift_arbiter: RTL

Shares one 16-bit shift/rotate unit between two requesters: the execute-stage ALU path (port 0) and a secondary client such as address alignment (port 1). Each port has a valid/ready request channel and a valid/ready response channel. At most one operation is in flight; results are registered and held until the owning requester takes them. The block sits in the execute stage beside the ALU and owns the only shifter instance in that stage.

---
 rtl/shift_arbiter_if.sv | 68 ++++++
 rtl/shift_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter_if
// Description : Request/response bundle between two requesters and the
//               shared shift/rotate unit (shift_arbiter).
//               slave  modport - seen by shift_arbiter
//               master modport - seen by the requesters (or a bench)
//               Port 0 and port 1 each carry:
//                 reqX_valid/reqX_ready  request handshake
//                 reqX_in/reqX_cnt/reqX_op operand, count, opcode
//                 respX_valid/respX_ready response handshake
//                 respX_out               result
//               busy: arbiter is holding a result (not IDLE)
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_arbiter_if #(
  parameter int N = 16,
  parameter int C = 4
);

  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_in;
  logic [C-1:0] req0_cnt;
  logic [1:0]   req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_in;
  logic [C-1:0] req1_cnt;
  logic [1:0]   req1_op;

  logic         resp0_valid;
  logic         resp0_ready;
  logic [N-1:0] resp0_out;

  logic         resp1_valid;
  logic         resp1_ready;
  logic [N-1:0] resp1_out;

  logic         busy;

  modport slave (
    input  req0_valid, req0_in, req0_cnt, req0_op,
    output req0_ready,
    input  req1_valid, req1_in, req1_cnt, req1_op,
    output req1_ready,
    output resp0_valid, resp0_out,
    input  resp0_ready,
    output resp1_valid, resp1_out,
    input  resp1_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_in, req0_cnt, req0_op,
    input  req0_ready,
    output req1_valid, req1_in, req1_cnt, req1_op,
    input  req1_ready,
    input  resp0_valid, resp0_out,
    output resp0_ready,
    input  resp1_valid, resp1_out,
    output resp1_ready,
    input  busy
  );

endinterface : shift_arbiter_if
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter
// Description : Shares one 16-bit shift/rotate unit between two requesters.
//               One operation in flight at a time; the result is registered
//               and held until the owning requester takes it.
//               Ports:
//                 clk  - system clock, rising edge
//                 rst  - synchronous active-high reset
//                 bus  - shift_arbiter_if.slave (request/response channels,
//                        busy)
//               Opcodes: 00 ROL, 01 SLL, 10 ROR, 11 SRL; count 0..15.
//               Build option:
//                 SHIFT_ARB_RR_EN defined   -> round-robin on contention
//                 SHIFT_ARB_RR_EN undefined -> port 0 fixed priority
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
  parameter int N = 16,  // data width, only 16 is supported
  parameter int C = 4    // shift count width, log2(N)
) (
  input  wire             clk,
  input  wire             rst,
  shift_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t       state_q,      state_d;
  logic [N-1:0] result_q,     result_d;
  logic         owner_q,      owner_d;       // 0: port 0 owns the result
  logic         last_grant_q, last_grant_d;  // port granted most recently

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic         grant0;
  logic         grant1;
  logic         accept;
  logic [N-1:0] sel_in;
  logic [C-1:0] sel_cnt;
  logic [1:0]   sel_op;
  logic [N-1:0] shift_result;
  logic         owner_resp_ready;

  logic         req0_ready;
  logic         req1_ready;
  logic         resp0_valid;
  logic         resp1_valid;

  // --------------------------------------------------------------------------
  // Shift/rotate unit. Rotates are done on a doubled operand so that a count
  // of zero needs no special case: the wanted half is the operand itself.
  // --------------------------------------------------------------------------
  function automatic logic [N-1:0] shift_op(
    input logic [N-1:0] x,
    input logic [C-1:0] cnt,
    input logic [1:0]   op
  );
    logic [2*N-1:0] dbl;
    logic [N-1:0]   res;
    dbl = {x, x};
    case (op)
      2'b00: begin  // ROL: upper half of doubled operand after left shift
        dbl = dbl << cnt;
        res = dbl[2*N-1:N];
      end
      2'b01: res = x << cnt;  // SLL, zero fill at LSB
      2'b10: begin  // ROR: lower half of doubled operand after right shift
        dbl = dbl >> cnt;
        res = dbl[N-1:0];
      end
      default: res = x >> cnt;  // SRL, zero fill at MSB
    endcase
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Arbitration. Grants are only meaningful in IDLE; ready is gated there.
  // --------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef SHIFT_ARB_RR_EN
    if (bus.req0_valid && bus.req1_valid) begin
      // contention: favour the port that did not win last time
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
`else
    // fixed priority; last_grant is tracked but does not steer the grant
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid & ~bus.req0_valid;
`endif
  end

  // Operand mux feeds the single shifter instance.
  always_comb begin
    sel_in  = grant1 ? bus.req1_in  : bus.req0_in;
    sel_cnt = grant1 ? bus.req1_cnt : bus.req0_cnt;
    sel_op  = grant1 ? bus.req1_op  : bus.req0_op;
  end

  assign shift_result     = shift_op(sel_in, sel_cnt, sel_op);
  assign accept           = (state_q == IDLE) && (grant0 || grant1);
  assign owner_resp_ready = owner_q ? bus.resp1_ready : bus.resp0_ready;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp0_valid  = 1'b0;
    resp1_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (accept) begin
          result_d     = shift_result;
          owner_d      = grant1;
          last_grant_d = grant1;
          state_d      = RESP;
        end
      end
      RESP: begin
        // only the owner sees valid; the other port's resp_ready is ignored
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        if (owner_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      result_q     <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // port 0 wins the first contention
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // --------------------------------------------------------------------------
  // Port drive. Both result buses show the shared result register; each is
  // only meaningful while its own valid is high.
  // --------------------------------------------------------------------------
  assign bus.req0_ready  = req0_ready;
  assign bus.req1_ready  = req1_ready;
  assign bus.resp0_valid = resp0_valid;
  assign bus.resp1_valid = resp1_valid;
  assign bus.resp0_out   = result_q;
  assign bus.resp1_out   = result_q;
  assign bus.busy        = (state_q != IDLE);

endmodule : shift_arbiter
`default_nettype wire
